// File: rtl/rtc_counter_pkg.sv
// Package rtc_pkg: shared types, limits and helpers for the real-time clock.
//   rtc_time_t  - packed time-of-day record (hour, min, sec, pm)
//   SEC_MAX, MIN_MAX, HOUR24_MAX, HOUR12_MAX - digit limits
//   time_legal  - range check applied to load requests
//   reset_time  - time value held while reset is asserted
package rtc_pkg;

   localparam logic [5:0] SEC_MAX    = 6'd59;
   localparam logic [5:0] MIN_MAX    = 6'd59;
   localparam logic [4:0] HOUR24_MAX = 5'd23;
   localparam logic [4:0] HOUR12_MAX = 5'd12;

   typedef struct packed {
      logic [4:0] hour;
      logic [5:0] min;
      logic [5:0] sec;
      logic       pm;
   } rtc_time_t;

   // 12-hour mode has no hour 0; 24-hour mode stops at 23.
   function automatic logic time_legal(input rtc_time_t t, input bit twelve_hr);
      logic hour_ok;
      if (twelve_hr) begin
         hour_ok = (t.hour >= 5'd1) && (t.hour <= HOUR12_MAX);
      end else begin
         hour_ok = (t.hour <= HOUR24_MAX);
      end
      return hour_ok && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
   endfunction

   // Midnight: 00:00:00 in 24-hour mode, 12:00:00 AM in 12-hour mode.
   function automatic rtc_time_t reset_time(input bit twelve_hr);
      rtc_time_t t;
      t      = '0;
      t.hour = twelve_hr ? HOUR12_MAX : 5'd0;
      return t;
   endfunction

endpackage

// File: rtl/rtc_counter_if.sv
// Interface rtc_counter_if: time-load handshake between a host and rtc_counter.
//   set_valid (host)  - load request
//   set_ready (clock) - load can be accepted
//   set_hour/set_min/set_sec/set_pm (host) - value to load
//   set_err   (clock) - one-cycle pulse after a rejected load
// Modports: master (host side), slave (clock side).
interface rtc_counter_if;

   logic       set_valid;
   logic       set_ready;
   logic [4:0] set_hour;
   logic [5:0] set_min;
   logic [5:0] set_sec;
   logic       set_pm;
   logic       set_err;

   modport master (
      output set_valid, set_hour, set_min, set_sec, set_pm,
      input  set_ready, set_err
   );

   modport slave (
      input  set_valid, set_hour, set_min, set_sec, set_pm,
      output set_ready, set_err
   );

endinterface

// File: rtl/rtc_counter_prescaler.sv
// Module rtc_prescaler: divides hs_clk down to one-second ticks.
//   hs_clk   in  - clock
//   reset    in  - synchronous, active-high
//   enable   in  - count advances while high, frozen while low
//   clear    in  - force the count back to 0 (accepted time load)
//   sec_tick out - high in the cycle the count sits at TICKS_PER_SEC-1 and advances
//   dot      out - high for the first half of each second
module rtc_prescaler #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
   input  logic hs_clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic sec_tick,
   output logic dot
);

   localparam int unsigned    CntW    = $clog2(TICKS_PER_SEC);
   localparam logic [CntW-1:0] CntMax  = CntW'(TICKS_PER_SEC - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(TICKS_PER_SEC / 2);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            at_max;

   assign at_max = (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q;
      if (reset || clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = at_max ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge hs_clk) begin
      cnt_q <= cnt_d;
   end

   // A load in the terminal cycle swallows the tick.
   assign sec_tick = enable & at_max & ~clear & ~reset;
   assign dot      = reset | (cnt_q < CntHalf);

endmodule

// File: rtl/rtc_counter.sv
// Module rtc_counter: binary time-of-day clock with load port and optional alarm.
// Parameters:
//   TICKS_PER_SEC - hs_clk cycles per second (>= 2, even)
//   TWELVE_HR     - 0: hours 0..23, 1: hours 1..12 with AM/PM flag
// Ports:
//   hs_clk, reset (sync, active-high), enable (freezes time and prescaler when low)
//   set_bus       - rtc_counter_if.slave load handshake
//   hour/min/sec/pm - registered current time
//   dot           - half-second blink
//   sec_tick      - pulse in the cycle the time advances (new time shows next cycle)
//   day_wrap      - pulse, coincident with the new time, at midnight rollover
// Build option: define RTC_ALARM_EN to add alarm_arm/alarm_hour/alarm_min/alarm_pm
// inputs and the alarm output pulse.
module rtc_counter
   import rtc_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter bit          TWELVE_HR     = 1'b0
) (
   input  logic         hs_clk,
   input  logic         reset,
   input  logic         enable,
   rtc_counter_if.slave set_bus,
   output logic [4:0]   hour,
   output logic [5:0]   min,
   output logic [5:0]   sec,
   output logic         pm,
   output logic         dot,
   output logic         sec_tick,
   output logic         day_wrap
`ifdef RTC_ALARM_EN
   ,
   input  logic         alarm_arm,
   input  logic [4:0]   alarm_hour,
   input  logic [5:0]   alarm_min,
   input  logic         alarm_pm,
   output logic         alarm
`endif
);

   rtc_time_t time_q, time_d;
   rtc_time_t load_time;
   rtc_time_t next_time;
   logic      rollover;
   logic      wrap_q, wrap_d;
   logic      err_q, err_d;
   logic      load_acc, load_legal, load_ok, load_bad;
   logic      tick;

   // ---------------------------------------------------------------- load port
   assign set_bus.set_ready = ~reset;
   assign set_bus.set_err   = err_q;

   always_comb begin
      load_time.hour = set_bus.set_hour;
      load_time.min  = set_bus.set_min;
      load_time.sec  = set_bus.set_sec;
      // 24-hour mode derives pm from the hour, so the stored flag stays 0.
      load_time.pm   = TWELVE_HR ? set_bus.set_pm : 1'b0;
   end

   assign load_acc   = set_bus.set_valid & set_bus.set_ready;
   assign load_legal = time_legal(load_time, TWELVE_HR);
   assign load_ok    = load_acc & load_legal;
   assign load_bad   = load_acc & ~load_legal;

   // ---------------------------------------------------------------- prescaler
   rtc_prescaler #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_prescaler (
      .hs_clk   (hs_clk),
      .reset    (reset),
      .enable   (enable),
      .clear    (load_ok),
      .sec_tick (tick),
      .dot      (dot)
   );

   // ---------------------------------------------------------------- increment
   always_comb begin
      next_time = time_q;
      rollover  = 1'b0;
      if (time_q.sec == SEC_MAX) begin
         next_time.sec = '0;
         if (time_q.min == MIN_MAX) begin
            next_time.min = '0;
            if (TWELVE_HR) begin
               if (time_q.hour == HOUR12_MAX) begin
                  next_time.hour = 5'd1;
               end else begin
                  next_time.hour = time_q.hour + 5'd1;
                  // 11 -> 12 flips the meridiem; only PM -> AM is a new day.
                  if (time_q.hour == HOUR12_MAX - 5'd1) begin
                     next_time.pm = ~time_q.pm;
                     rollover     = time_q.pm;
                  end
               end
            end else if (time_q.hour == HOUR24_MAX) begin
               next_time.hour = '0;
               rollover       = 1'b1;
            end else begin
               next_time.hour = time_q.hour + 5'd1;
            end
         end else begin
            next_time.min = time_q.min + 6'd1;
         end
      end else begin
         next_time.sec = time_q.sec + 6'd1;
      end
   end

   // ---------------------------------------------------------------- state
   always_comb begin
      time_d = time_q;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      if (reset) begin
         time_d = reset_time(TWELVE_HR);
      end else if (load_ok) begin
         time_d = load_time;
      end else begin
         if (tick) begin
            time_d = next_time;
            wrap_d = rollover;
         end
         err_d = load_bad;
      end
   end

   always_ff @(posedge hs_clk) begin
      time_q <= time_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
   end

   assign hour     = time_q.hour;
   assign min      = time_q.min;
   assign sec      = time_q.sec;
   assign pm       = TWELVE_HR ? time_q.pm : (time_q.hour >= 5'd12);
   assign sec_tick = tick;
   assign day_wrap = wrap_q;

`ifdef RTC_ALARM_EN
   // ---------------------------------------------------------------- alarm
   logic alarm_q, alarm_d;

   // Only a tick can raise the alarm, so loading the alarm time stays silent.
   always_comb begin
      alarm_d = 1'b0;
      if (!reset && !load_ok && tick && alarm_arm &&
          (next_time.sec == 6'd0) &&
          (next_time.hour == alarm_hour) &&
          (next_time.min == alarm_min) &&
          (!TWELVE_HR || (next_time.pm == alarm_pm))) begin
         alarm_d = 1'b1;
      end
   end

   always_ff @(posedge hs_clk) begin
      alarm_q <= alarm_d;
   end

   assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_counter.sv
// Testbench for rtc_counter with TICKS_PER_SEC=4: one 24-hour and one 12-hour
// instance sharing clock, reset and enable, each with its own load interface.
module tb_rtc_counter;
   import rtc_pkg::*;

   localparam int unsigned Tps = 4;

   logic hs_clk = 1'b0;
   logic reset;
   logic enable;

   rtc_counter_if if24 ();
   rtc_counter_if if12 ();

   logic [4:0] hour24, hour12;
   logic [5:0] min24, min12, sec24, sec12;
   logic       pm24, pm12, dot24, dot12, tick24, tick12, wrap24, wrap12;
`ifdef RTC_ALARM_EN
   logic       alarm_arm;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_min;
   logic       alarm_pm;
   logic       alarm24, alarm12;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 hs_clk = ~hs_clk;

   rtc_counter #(
      .TICKS_PER_SEC (Tps),
      .TWELVE_HR     (1'b0)
   ) u24 (
      .hs_clk   (hs_clk),
      .reset    (reset),
      .enable   (enable),
      .set_bus  (if24),
      .hour     (hour24),
      .min      (min24),
      .sec      (sec24),
      .pm       (pm24),
      .dot      (dot24),
      .sec_tick (tick24),
      .day_wrap (wrap24)
`ifdef RTC_ALARM_EN
      ,
      .alarm_arm  (alarm_arm),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .alarm_pm   (alarm_pm),
      .alarm      (alarm24)
`endif
   );

   rtc_counter #(
      .TICKS_PER_SEC (Tps),
      .TWELVE_HR     (1'b1)
   ) u12 (
      .hs_clk   (hs_clk),
      .reset    (reset),
      .enable   (enable),
      .set_bus  (if12),
      .hour     (hour12),
      .min      (min12),
      .sec      (sec12),
      .pm       (pm12),
      .dot      (dot12),
      .sec_tick (tick12),
      .day_wrap (wrap12)
`ifdef RTC_ALARM_EN
      ,
      .alarm_arm  (alarm_arm),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .alarm_pm   (alarm_pm),
      .alarm      (alarm12)
`endif
   );

   // ---------------------------------------------------------------- helpers
   typedef struct {
      string     name;
      rtc_time_t t;
      logic      err;
      logic      wrap;
   } exp_t;

   typedef struct {
      string     name;
      rtc_time_t ld;
      rtc_time_t ex;
      logic      err;
   } vec_t;

   exp_t sb[$];
   vec_t v24[9];
   vec_t v12[5];

   function automatic rtc_time_t mk(input int h, input int m, input int s, input bit p);
      rtc_time_t t;
      t.hour = 5'(h);
      t.min  = 6'(m);
      t.sec  = 6'(s);
      t.pm   = p;
      return t;
   endfunction

   function automatic vec_t mkv(input string n, input rtc_time_t ld, input rtc_time_t ex,
                                input logic err);
      vec_t v;
      v.name = n;
      v.ld   = ld;
      v.ex   = ex;
      v.err  = err;
      return v;
   endfunction

   function automatic rtc_time_t cur_time(input bit sel);
      rtc_time_t t;
      if (sel) t = {hour12, min12, sec12, pm12};
      else     t = {hour24, min24, sec24, pm24};
      return t;
   endfunction

   function automatic logic cur_tick(input bit sel);
      return sel ? tick12 : tick24;
   endfunction

   function automatic logic cur_wrap(input bit sel);
      return sel ? wrap12 : wrap24;
   endfunction

   function automatic logic cur_err(input bit sel);
      return sel ? if12.set_err : if24.set_err;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Sample and drive 1 time unit after the falling edge.
   task automatic step();
      @(negedge hs_clk);
      #1;
   endtask

   task automatic push_exp(input string name, input rtc_time_t t, input logic err,
                           input logic wrap);
      exp_t e;
      e.name = name;
      e.t    = t;
      e.err  = err;
      e.wrap = wrap;
      sb.push_back(e);
   endtask

   task automatic sb_check(input bit sel);
      exp_t      e;
      rtc_time_t a;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: nothing queued, expected an entry");
         return;
      end
      e = sb.pop_front();
      a = cur_time(sel);
      check({e.name, ".hour"}, 32'(a.hour), 32'(e.t.hour));
      check({e.name, ".min"},  32'(a.min),  32'(e.t.min));
      check({e.name, ".sec"},  32'(a.sec),  32'(e.t.sec));
      check({e.name, ".pm"},   32'(a.pm),   32'(e.t.pm));
      check({e.name, ".err"},  32'(cur_err(sel)),  32'(e.err));
      check({e.name, ".wrap"}, 32'(cur_wrap(sel)), 32'(e.wrap));
   endtask

   task automatic drive_load(input bit sel, input rtc_time_t t);
      if (sel) begin
         if12.set_valid = 1'b1;
         if12.set_hour  = t.hour;
         if12.set_min   = t.min;
         if12.set_sec   = t.sec;
         if12.set_pm    = t.pm;
      end else begin
         if24.set_valid = 1'b1;
         if24.set_hour  = t.hour;
         if24.set_min   = t.min;
         if24.set_sec   = t.sec;
         if24.set_pm    = t.pm;
      end
   endtask

   task automatic drop_load();
      if12.set_valid = 1'b0;
      if24.set_valid = 1'b0;
   endtask

   task automatic load_and_check(input bit sel, input string name, input rtc_time_t ld,
                                 input rtc_time_t ex, input logic err);
      push_exp(name, ex, err, 1'b0);
      drive_load(sel, ld);
      step();
      drop_load();
      sb_check(sel);
      step();
      check({name, ".err_gone"}, 32'(cur_err(sel)), 32'd0);
   endtask

   task automatic wait_tick(input bit sel, input int unsigned bound, output int unsigned waited);
      waited = 0;
      while (!cur_tick(sel) && waited < bound) begin
         step();
         waited++;
      end
      n_tests++;
      if (!cur_tick(sel)) begin
         n_fail++;
         $display("FAIL wait_tick: no sec_tick within %0d cycles, expected one", bound);
      end
   endtask

   task automatic tick_and_check(input bit sel, input string name, input rtc_time_t ex,
                                 input logic wrap);
      int unsigned w;
      enable = 1'b1;
      #1;
      wait_tick(sel, 2 * Tps + 2, w);
      push_exp(name, ex, 1'b0, wrap);
      step();
      enable = 1'b0;
      sb_check(sel);
      step();
      check({name, ".wrap_gone"}, 32'(cur_wrap(sel)), 32'd0);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- main
   initial begin
      int unsigned ticks24, ticks12, wraps, w;
`ifdef RTC_ALARM_EN
      int unsigned n_al24, n_al12;
`endif

      v24[0] = mkv("ld24_12_34_56", mk(12, 34, 56, 0), mk(12, 34, 56, 1), 1'b0);
      v24[1] = mkv("ld24_24_00_00", mk(24,  0,  0, 0), mk(12, 34, 56, 1), 1'b1);
      v24[2] = mkv("ld24_00_60_00", mk( 0, 60,  0, 0), mk(12, 34, 56, 1), 1'b1);
      v24[3] = mkv("ld24_00_00_60", mk( 0,  0, 60, 0), mk(12, 34, 56, 1), 1'b1);
      v24[4] = mkv("ld24_23_59_59", mk(23, 59, 59, 0), mk(23, 59, 59, 1), 1'b0);
      v24[5] = mkv("ld24_31_63_63", mk(31, 63, 63, 0), mk(23, 59, 59, 1), 1'b1);
      v24[6] = mkv("ld24_00_00_00", mk( 0,  0,  0, 0), mk( 0,  0,  0, 0), 1'b0);
      v24[7] = mkv("ld24_11_59_59", mk(11, 59, 59, 0), mk(11, 59, 59, 0), 1'b0);
      v24[8] = mkv("ld24_pm_ignored", mk(9, 8, 7, 1), mk( 9,  8,  7, 0), 1'b0);

      v12[0] = mkv("ld12_01_02_03p", mk( 1,  2,  3, 1), mk( 1,  2,  3, 1), 1'b0);
      v12[1] = mkv("ld12_00_10_00",  mk( 0, 10,  0, 0), mk( 1,  2,  3, 1), 1'b1);
      v12[2] = mkv("ld12_13_00_00",  mk(13,  0,  0, 0), mk( 1,  2,  3, 1), 1'b1);
      v12[3] = mkv("ld12_12_00_00a", mk(12,  0,  0, 0), mk(12,  0,  0, 0), 1'b0);
      v12[4] = mkv("ld12_12_60_00",  mk(12, 60,  0, 1), mk(12,  0,  0, 0), 1'b1);

      reset  = 1'b1;
      enable = 1'b0;
      drop_load();
      drive_load(0, mk(0, 0, 0, 0));
      drive_load(1, mk(0, 0, 0, 0));
      drop_load();
`ifdef RTC_ALARM_EN
      alarm_arm  = 1'b0;
      alarm_hour = '0;
      alarm_min  = '0;
      alarm_pm   = 1'b0;
`endif

      // Reset state
      repeat (3) step();
      push_exp("rst24", mk(0, 0, 0, 0), 1'b0, 1'b0);
      sb_check(0);
      push_exp("rst12", mk(12, 0, 0, 0), 1'b0, 1'b0);
      sb_check(1);
      check("rst24.dot",   32'(dot24), 32'd1);
      check("rst12.dot",   32'(dot12), 32'd1);
      check("rst24.ready", 32'(if24.set_ready), 32'd0);
      check("rst24.tick",  32'(tick24), 32'd0);

      // One minute of free running
      reset  = 1'b0;
      enable = 1'b1;
      #1;
      check("run.ready", 32'(if24.set_ready), 32'd1);
      ticks24 = 0;
      ticks12 = 0;
      wraps   = 0;
      for (int i = 0; i < 240; i++) begin
         step();
         if (tick24) ticks24++;
         if (tick12) ticks12++;
         if (wrap24) wraps++;
      end
      enable = 1'b0;
      check("run.ticks24", ticks24, 32'd60);
      check("run.ticks12", ticks12, 32'd60);
      check("run.wraps24", wraps, 32'd0);
      push_exp("run24", mk(0, 1, 0, 0), 1'b0, 1'b0);
      sb_check(0);
      push_exp("run12", mk(12, 1, 0, 0), 1'b0, 1'b0);
      sb_check(1);

      // Disable exactly at the terminal count, then resume
      enable = 1'b1;
      #1;
      wait_tick(0, 2 * Tps + 2, w);
      enable = 1'b0;
      #1;
      check("hold.no_tick", 32'(tick24), 32'd0);
      repeat (3) step();
      check("hold.dot_frozen", 32'(dot24), 32'd0);
      check("hold.sec", 32'(sec24), 32'd0);
      enable = 1'b1;
      #1;
      check("hold.resume_tick", 32'(tick24), 32'd1);
      push_exp("hold.after", mk(0, 1, 1, 0), 1'b0, 1'b0);
      step();
      enable = 1'b0;
      sb_check(0);

      // Load vectors, 24-hour
      for (int i = 0; i < 9; i++) begin
         load_and_check(0, v24[i].name, v24[i].ld, v24[i].ex, v24[i].err);
      end

      // Midnight rollover, 24-hour
      load_and_check(0, "wrap24.load", mk(23, 59, 59, 0), mk(23, 59, 59, 1), 1'b0);
      tick_and_check(0, "wrap24.tick", mk(0, 0, 0, 0), 1'b1);

      // Load in the same cycle as a tick
      enable = 1'b1;
      #1;
      wait_tick(0, 2 * Tps + 2, w);
      drive_load(0, mk(5, 6, 7, 0));
      #1;
      check("loadtick.tick_dropped", 32'(tick24), 32'd0);
      push_exp("loadtick.value", mk(5, 6, 7, 0), 1'b0, 1'b0);
      step();
      drop_load();
      sb_check(0);
      wait_tick(0, 2 * Tps + 2, w);
      check("loadtick.gap", w, 32'd3);
      push_exp("loadtick.next", mk(5, 6, 8, 0), 1'b0, 1'b0);
      step();
      enable = 1'b0;
      sb_check(0);

      // Load vectors, 12-hour
      for (int i = 0; i < 5; i++) begin
         load_and_check(1, v12[i].name, v12[i].ld, v12[i].ex, v12[i].err);
      end

      // Meridiem handling, 12-hour
      load_and_check(1, "am_pm.load", mk(11, 59, 59, 0), mk(11, 59, 59, 0), 1'b0);
      tick_and_check(1, "am_pm.tick", mk(12, 0, 0, 1), 1'b0);
      load_and_check(1, "h12_1.load", mk(12, 59, 59, 1), mk(12, 59, 59, 1), 1'b0);
      tick_and_check(1, "h12_1.tick", mk(1, 0, 0, 1), 1'b0);
      load_and_check(1, "pm_am.load", mk(11, 59, 59, 1), mk(11, 59, 59, 1), 1'b0);
      tick_and_check(1, "pm_am.tick", mk(12, 0, 0, 0), 1'b1);

      // Reset mid-second, with a load request competing
      enable = 1'b1;
      repeat (2) step();
      reset = 1'b1;
      drive_load(0, mk(5, 5, 5, 0));
      step();
      push_exp("midrst", mk(0, 0, 0, 0), 1'b0, 1'b0);
      sb_check(0);
      check("midrst.ready", 32'(if24.set_ready), 32'd0);
      check("midrst.dot",   32'(dot24), 32'd1);
      check("midrst.tick",  32'(tick24), 32'd0);
      check("midrst.hour12", 32'(hour12), 32'd12);
      reset = 1'b0;
      drop_load();
      #1;
      wait_tick(0, 2 * Tps + 2, w);
      check("midrst.gap", w, 32'd3);
      push_exp("midrst.first_sec", mk(0, 0, 1, 0), 1'b0, 1'b0);
      step();
      enable = 1'b0;
      sb_check(0);

`ifdef RTC_ALARM_EN
      // Alarm at 00:01, armed then disarmed
      for (int arm = 1; arm >= 0; arm--) begin
         reset = 1'b1;
         step();
         reset      = 1'b0;
         alarm_arm  = arm[0];
         alarm_hour = 5'd0;
         alarm_min  = 6'd1;
         alarm_pm   = 1'b0;
         enable     = 1'b1;
         n_al24     = 0;
         n_al12     = 0;
         for (int i = 0; i < 240; i++) begin
            step();
            if (alarm24) begin
               n_al24++;
               check("alarm.time", 32'({hour24, min24, sec24}), 32'({5'd0, 6'd1, 6'd0}));
            end
            if (alarm12) n_al12++;
         end
         enable = 1'b0;
         check(arm[0] ? "alarm.armed_count" : "alarm.disarmed_count", n_al24, 32'(arm));
         check("alarm.count12", n_al12, 32'd0);
      end
      alarm_arm = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
